// File: rtl/cu_pkg.sv
// cu_pkg: shared state encoding, trap causes, opcodes, alu_op codes and decode bundle for mc_control_unit
package cu_pkg;
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_MULDIV = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;
  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_IMEM    = 2'd2;
  localparam logic [1:0] CAUSE_DMEM    = 2'd3;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b10;
  localparam logic [1:0] ALU_LUI = 2'b11;
  typedef struct packed {
    logic       alu_src;
    logic       mem_to_reg;
    logic       branch;
    logic       jump;
    logic       jump_r;
    logic       auipc;
    logic [1:0] alu_op;
    logic       is_load;
    logic       is_store;
    logic       is_md;
  } dec_t;
endpackage

// File: rtl/cu_decode.sv
// cu_decode: combinational opcode/funct7 decode into control bits plus illegal flag
// Ports: opcode, funct7 in; dec (decode bundle), illegal out.
// CU_MEXT_EN: when defined, funct7=0000001 on R-type decodes as mul/div; otherwise it is illegal.
module cu_decode
  import cu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [6:0] funct7,
  output dec_t       dec,
  output logic       illegal
);
  always_comb begin
    dec = '0;
    illegal = 1'b0;
    case (opcode)
      OP_LUI: begin
        dec.alu_src = 1'b1;
        dec.alu_op = ALU_LUI;
      end
      OP_AUIPC: begin
        dec.alu_src = 1'b1;
        dec.auipc = 1'b1;
      end
      OP_JAL: begin
        dec.alu_src = 1'b1;
        dec.jump = 1'b1;
      end
      OP_JALR: begin
        dec.alu_src = 1'b1;
        dec.jump_r = 1'b1;
      end
      OP_BRANCH: begin
        dec.branch = 1'b1;
        dec.alu_op = ALU_BR;
      end
      OP_LOAD: begin
        dec.alu_src = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.is_load = 1'b1;
      end
      OP_STORE: begin
        dec.alu_src = 1'b1;
        dec.is_store = 1'b1;
      end
      OP_IMM: begin
        dec.alu_src = 1'b1;
        dec.alu_op = ALU_R;
      end
      OP_REG: begin
        dec.alu_op = ALU_R;
        if (funct7 == F7_MULDIV) begin
`ifdef CU_MEXT_EN
          dec.is_md = 1'b1;
`else
          illegal = 1'b1;
`endif
        end
      end
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle RV32IM control FSM with memory timeouts, traps and retire counter
// Ports: clk, rst; opcode/funct7 from IR; imem_ready, dmem_ready, md_done, branch_taken, trap_ack in;
// memory requests, datapath controls, md_start, trap/trap_cause, state and retire_count out.
// CU_MEXT_EN: when defined, mul/div instructions go through the MULDIV state; otherwise they trap as illegal.
module mc_control_unit
  import cu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [6:0]       funct7,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             md_done,
  input  logic             branch_taken,
  input  logic             trap_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             alu_src,
  output logic             branch,
  output logic             jump,
  output logic             jump_r,
  output logic             auipc,
  output logic [1:0]       alu_op,
  output logic             md_start,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retire_count
);
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  state_t cur, nxt;
  dec_t dec, dr;
  logic illegal, retire, waiting, at_limit;
  logic [TW-1:0] tcnt;
  // The datapath picks the branch target itself; PC is written either way.
  logic unused_branch_taken;
  assign unused_branch_taken = branch_taken;
  cu_decode u_decode (
    .opcode (opcode),
    .funct7 (funct7),
    .dec    (dec),
    .illegal(illegal)
  );
  assign state = cur;
  assign {alu_src, mem_to_reg, branch, jump, jump_r, auipc, alu_op} =
    {dr.alu_src, dr.mem_to_reg, dr.branch, dr.jump, dr.jump_r, dr.auipc, dr.alu_op};
  assign waiting = cur == S_FETCH || cur == S_MEM;
  assign at_limit = tcnt == TW'(MEM_TIMEOUT);
  assign retire = nxt == S_FETCH && cur != S_FETCH && cur != S_TRAP;
  always_ff @(posedge clk) begin
    if (rst) cur <= S_FETCH;
    else cur <= nxt;
  end
  always_comb begin
    nxt = cur;
    case (cur)
      S_FETCH:  nxt = imem_ready ? S_DECODE : at_limit ? S_TRAP : S_FETCH;
      S_DECODE: nxt = illegal ? S_TRAP : S_EXEC;
      S_EXEC:   nxt = (dr.is_load || dr.is_store) ? S_MEM : dr.branch ? S_FETCH : dr.is_md ? S_MULDIV : S_WB;
      S_MEM:    nxt = dmem_ready ? (dr.is_load ? S_WB : S_FETCH) : at_limit ? S_TRAP : S_MEM;
      S_MULDIV: nxt = (md_done && !md_start) ? S_WB : S_MULDIV;
      S_WB:     nxt = S_FETCH;
      S_TRAP:   nxt = trap_ack ? S_FETCH : S_TRAP;
      default:  nxt = S_FETCH;
    endcase
  end
`ifdef CU_MEXT_EN
  logic md_prev;
  always_ff @(posedge clk) begin
    if (rst) md_prev <= 1'b0;
    else md_prev <= cur == S_MULDIV;
  end
`endif
  always_comb begin
    imem_req = cur == S_FETCH && !rst;
    ir_write = cur == S_FETCH && imem_ready;
    dmem_req = cur == S_MEM;
    mem_read = dmem_req && dr.is_load;
    mem_write = dmem_req && dr.is_store;
    reg_write = cur == S_WB;
    pc_write = (cur == S_EXEC && dr.branch) || (cur == S_MEM && dmem_ready && dr.is_store)
             || cur == S_WB || (cur == S_TRAP && trap_ack);
    trap = cur == S_TRAP;
`ifdef CU_MEXT_EN
    md_start = cur == S_MULDIV && !md_prev;
`else
    md_start = 1'b0;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      dr <= '0;
      tcnt <= '0;
      trap_cause <= CAUSE_NONE;
      retire_count <= '0;
    end else begin
      if (cur == S_DECODE) dr <= dec;
      tcnt <= (nxt != cur) ? '0 : waiting ? tcnt + TW'(1) : tcnt;
      trap_cause <= (cur == S_TRAP) ? (trap_ack ? CAUSE_NONE : trap_cause)
                  : (nxt == S_TRAP) ? (cur == S_DECODE ? CAUSE_ILLEGAL : cur == S_FETCH ? CAUSE_IMEM : CAUSE_DMEM)
                  : trap_cause;
      if (retire) retire_count <= retire_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: scoreboard bench for mc_control_unit with MEM_TIMEOUT=4
module tb_mc_control_unit;
  localparam logic [2:0] SF = 3'd0, SD = 3'd1, SE = 3'd2, SM = 3'd3, SX = 3'd4, SW = 3'd5, ST = 3'd6;
  localparam logic [8:0] IREQ = 9'h100, IRW = 9'h080, DREQ = 9'h040, MRD = 9'h020, MWR = 9'h010;
  localparam logic [8:0] RW = 9'h008, PCW = 9'h004, MDS = 9'h002, TRP = 9'h001, Z = 9'h000;
  localparam logic [3:0] IR = 4'b1000, DR = 4'b0100, MD = 4'b0010, AK = 4'b0001, NO = 4'b0000;
  localparam logic [1:0] C0 = 2'd0, C1 = 2'd1, C2 = 2'd2, C3 = 2'd3;
  localparam logic [6:0] LUI = 7'b0110111, AUI = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111;
  localparam logic [6:0] BEQ = 7'b1100011, LW = 7'b0000011, SW_ = 7'b0100011, ADDI = 7'b0010011;
  localparam logic [6:0] RTYP = 7'b0110011, BAD = 7'b1111111;
  typedef struct packed {
    logic [6:0] op;
    logic [3:0] in;
    logic [2:0] st;
    logic [8:0] b;
    logic [1:0] c;
  } cyc_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [6:0] opcode = '0, funct7 = '0;
  logic imem_ready = 1'b0, dmem_ready = 1'b0, md_done = 1'b0, branch_taken = 1'b0, trap_ack = 1'b0;
  logic imem_req, dmem_req, ir_write, pc_write, reg_write, mem_read, mem_write, mem_to_reg;
  logic alu_src, branch, jump, jump_r, auipc, md_start, trap;
  logic [1:0] alu_op, trap_cause;
  logic [2:0] state;
  logic [31:0] retire_count;
  int total = 0, bad = 0, exp_ret = 0;
  cyc_t sb[$];
  always #5 clk = ~clk;
  mc_control_unit #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct7(funct7), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .md_done(md_done), .branch_taken(branch_taken), .trap_ack(trap_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .alu_src(alu_src), .branch(branch), .jump(jump), .jump_r(jump_r), .auipc(auipc), .alu_op(alu_op),
    .md_start(md_start), .trap(trap), .trap_cause(trap_cause), .state(state), .retire_count(retire_count)
  );
  function automatic logic [8:0] obs();
    return {imem_req, ir_write, dmem_req, mem_read, mem_write, reg_write, pc_write, md_start, trap};
  endfunction
  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({state, obs(), trap_cause, retire_count} !== {SF, Z, C0, 32'd0}) begin
      bad++;
      $display("FAIL reset st=%0d out=%b cause=%0d ret=%0d want st=0 out=0 cause=0 ret=0", state, obs(), trap_cause, retire_count);
    end
    total++;
    if ({alu_src, mem_to_reg, branch, jump, jump_r, auipc, alu_op} !== 8'd0) begin
      bad++;
      $display("FAIL reset_dec got %b want 00000000", {alu_src, mem_to_reg, branch, jump, jump_r, auipc, alu_op});
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask
  task automatic test_addi();
    cyc_t e;
    cyc_t t[$] = '{'{ADDI, IR, SF, IREQ | IRW, C0}, '{ADDI, AK, SD, Z, C0}, '{ADDI, NO, SE, Z, C0}, '{ADDI, NO, SW, RW | PCW, C0}};
    foreach (t[i]) begin
      opcode = t[i].op;
      {imem_ready, dmem_ready, md_done, trap_ack} = t[i].in;
      sb.push_back(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({state, obs(), trap_cause} !== {e.st, e.b, e.c}) begin
        bad++;
        $display("FAIL addi[%0d] st=%0d out=%b cause=%0d want st=%0d out=%b cause=%0d", i, state, obs(), trap_cause, e.st, e.b, e.c);
      end
      @(posedge clk); #1;
    end
    exp_ret = 1;
    total++;
    if ({retire_count, alu_src} !== {32'(exp_ret), 1'b1}) begin
      bad++;
      $display("FAIL addi_ret ret=%0d alu_src=%b want ret=%0d alu_src=1", retire_count, alu_src, exp_ret);
    end
  endtask
  task automatic test_load();
    cyc_t e;
    cyc_t t[$] = '{'{LW, IR, SF, IREQ | IRW, C0}, '{LW, NO, SD, Z, C0}, '{LW, NO, SE, Z, C0},
                   '{LW, NO, SM, DREQ | MRD, C0}, '{LW, NO, SM, DREQ | MRD, C0}, '{LW, NO, SM, DREQ | MRD, C0},
                   '{LW, DR, SM, DREQ | MRD, C0}, '{LW, NO, SW, RW | PCW, C0}};
    foreach (t[i]) begin
      opcode = t[i].op;
      {imem_ready, dmem_ready, md_done, trap_ack} = t[i].in;
      sb.push_back(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({state, obs(), trap_cause} !== {e.st, e.b, e.c}) begin
        bad++;
        $display("FAIL load[%0d] st=%0d out=%b cause=%0d want st=%0d out=%b cause=%0d", i, state, obs(), trap_cause, e.st, e.b, e.c);
      end
      @(posedge clk); #1;
    end
    exp_ret = 2;
    total++;
    if ({retire_count, mem_to_reg} !== {32'(exp_ret), 1'b1}) begin
      bad++;
      $display("FAIL load_ret ret=%0d mem_to_reg=%b want ret=%0d mem_to_reg=1", retire_count, mem_to_reg, exp_ret);
    end
  endtask
  task automatic test_store();
    cyc_t e;
    cyc_t t[$] = '{'{SW_, IR, SF, IREQ | IRW, C0}, '{SW_, NO, SD, Z, C0}, '{SW_, AK, SE, Z, C0},
                   '{SW_, DR, SM, DREQ | MWR | PCW, C0}};
    foreach (t[i]) begin
      opcode = t[i].op;
      {imem_ready, dmem_ready, md_done, trap_ack} = t[i].in;
      sb.push_back(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({state, obs(), trap_cause} !== {e.st, e.b, e.c}) begin
        bad++;
        $display("FAIL store[%0d] st=%0d out=%b cause=%0d want st=%0d out=%b cause=%0d", i, state, obs(), trap_cause, e.st, e.b, e.c);
      end
      @(posedge clk); #1;
    end
    exp_ret = 3;
    total++;
    if ({retire_count, mem_to_reg} !== {32'(exp_ret), 1'b0}) begin
      bad++;
      $display("FAIL store_ret ret=%0d mem_to_reg=%b want ret=%0d mem_to_reg=0", retire_count, mem_to_reg, exp_ret);
    end
  endtask
  task automatic test_branch();
    cyc_t e;
    cyc_t t[$] = '{'{BEQ, IR, SF, IREQ | IRW, C0}, '{BEQ, NO, SD, Z, C0}, '{BEQ, NO, SE, PCW, C0}};
    branch_taken = 1'b1;
    foreach (t[i]) begin
      opcode = t[i].op;
      {imem_ready, dmem_ready, md_done, trap_ack} = t[i].in;
      sb.push_back(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({state, obs(), trap_cause} !== {e.st, e.b, e.c}) begin
        bad++;
        $display("FAIL branch[%0d] st=%0d out=%b cause=%0d want st=%0d out=%b cause=%0d", i, state, obs(), trap_cause, e.st, e.b, e.c);
      end
      @(posedge clk); #1;
    end
    branch_taken = 1'b0;
    exp_ret = 4;
    total++;
    if ({retire_count, branch, alu_op} !== {32'(exp_ret), 1'b1, 2'b01}) begin
      bad++;
      $display("FAIL branch_ret ret=%0d branch=%b alu_op=%b want ret=%0d branch=1 alu_op=01", retire_count, branch, alu_op, exp_ret);
    end
  endtask
  task automatic test_back_to_back();
    cyc_t e;
    cyc_t t[$] = '{'{JAL, IR, SF, IREQ | IRW, C0}, '{JAL, NO, SD, Z, C0}, '{JAL, NO, SE, Z, C0}, '{JAL, NO, SW, RW | PCW, C0},
                   '{AUI, IR, SF, IREQ | IRW, C0}, '{AUI, NO, SD, Z, C0}, '{AUI, NO, SE, Z, C0}, '{AUI, NO, SW, RW | PCW, C0},
                   '{JALR, IR, SF, IREQ | IRW, C0}, '{JALR, NO, SD, Z, C0}, '{JALR, NO, SE, Z, C0}, '{JALR, NO, SW, RW | PCW, C0},
                   '{LUI, IR, SF, IREQ | IRW, C0}, '{LUI, NO, SD, Z, C0}, '{LUI, NO, SE, Z, C0}, '{LUI, NO, SW, RW | PCW, C0}};
    foreach (t[i]) begin
      opcode = t[i].op;
      {imem_ready, dmem_ready, md_done, trap_ack} = t[i].in;
      sb.push_back(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({state, obs(), trap_cause} !== {e.st, e.b, e.c}) begin
        bad++;
        $display("FAIL b2b[%0d] st=%0d out=%b cause=%0d want st=%0d out=%b cause=%0d", i, state, obs(), trap_cause, e.st, e.b, e.c);
      end
      if (i == 11) begin
        total++;
        if ({jump, jump_r, auipc, alu_op} !== 5'b01000) begin
          bad++;
          $display("FAIL jalr_dec got %b want 01000", {jump, jump_r, auipc, alu_op});
        end
      end
      @(posedge clk); #1;
    end
    exp_ret = 8;
    total++;
    if ({retire_count, alu_op, alu_src, jump_r} !== {32'(exp_ret), 2'b11, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL lui_ret ret=%0d alu_op=%b alu_src=%b jump_r=%b want ret=%0d 11 1 0", retire_count, alu_op, alu_src, jump_r, exp_ret);
    end
  endtask
  task automatic test_illegal();
    cyc_t e;
    cyc_t t[$] = '{'{BAD, IR, SF, IREQ | IRW, C0}, '{BAD, NO, SD, Z, C0}, '{BAD, NO, ST, TRP, C1},
                   '{BAD, NO, ST, TRP, C1}, '{BAD, AK, ST, TRP | PCW, C1}};
    foreach (t[i]) begin
      opcode = t[i].op;
      {imem_ready, dmem_ready, md_done, trap_ack} = t[i].in;
      sb.push_back(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({state, obs(), trap_cause} !== {e.st, e.b, e.c}) begin
        bad++;
        $display("FAIL illegal[%0d] st=%0d out=%b cause=%0d want st=%0d out=%b cause=%0d", i, state, obs(), trap_cause, e.st, e.b, e.c);
      end
      @(posedge clk); #1;
    end
    trap_ack = 1'b0;
    total++;
    if ({state, trap, trap_cause, retire_count} !== {SF, 1'b0, C0, 32'(exp_ret)}) begin
      bad++;
      $display("FAIL illegal_exit st=%0d trap=%b cause=%0d ret=%0d want st=0 trap=0 cause=0 ret=%0d", state, trap, trap_cause, retire_count, exp_ret);
    end
  endtask
  task automatic test_imem_timeout();
    cyc_t e;
    cyc_t t[$] = '{'{ADDI, NO, SF, IREQ, C0}, '{ADDI, NO, SF, IREQ, C0}, '{ADDI, NO, SF, IREQ, C0},
                   '{ADDI, NO, SF, IREQ, C0}, '{ADDI, NO, SF, IREQ, C0}, '{ADDI, AK, ST, TRP | PCW, C2},
                   '{ADDI, NO, SF, IREQ, C0}, '{ADDI, NO, SF, IREQ, C0}, '{ADDI, NO, SF, IREQ, C0},
                   '{ADDI, NO, SF, IREQ, C0}, '{ADDI, IR, SF, IREQ | IRW, C0}, '{ADDI, NO, SD, Z, C0},
                   '{ADDI, NO, SE, Z, C0}, '{ADDI, NO, SW, RW | PCW, C0}};
    foreach (t[i]) begin
      opcode = t[i].op;
      {imem_ready, dmem_ready, md_done, trap_ack} = t[i].in;
      sb.push_back(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({state, obs(), trap_cause} !== {e.st, e.b, e.c}) begin
        bad++;
        $display("FAIL imem_to[%0d] st=%0d out=%b cause=%0d want st=%0d out=%b cause=%0d", i, state, obs(), trap_cause, e.st, e.b, e.c);
      end
      @(posedge clk); #1;
    end
    exp_ret = 9;
    total++;
    if (retire_count !== 32'(exp_ret)) begin
      bad++;
      $display("FAIL imem_to_ret got %0d want %0d", retire_count, exp_ret);
    end
  endtask
  task automatic test_dmem_timeout();
    cyc_t e;
    cyc_t t[$] = '{'{LW, IR, SF, IREQ | IRW, C0}, '{LW, NO, SD, Z, C0}, '{LW, NO, SE, Z, C0},
                   '{LW, NO, SM, DREQ | MRD, C0}, '{LW, NO, SM, DREQ | MRD, C0}, '{LW, NO, SM, DREQ | MRD, C0},
                   '{LW, NO, SM, DREQ | MRD, C0}, '{LW, NO, SM, DREQ | MRD, C0}, '{LW, AK, ST, TRP | PCW, C3}};
    foreach (t[i]) begin
      opcode = t[i].op;
      {imem_ready, dmem_ready, md_done, trap_ack} = t[i].in;
      sb.push_back(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({state, obs(), trap_cause} !== {e.st, e.b, e.c}) begin
        bad++;
        $display("FAIL dmem_to[%0d] st=%0d out=%b cause=%0d want st=%0d out=%b cause=%0d", i, state, obs(), trap_cause, e.st, e.b, e.c);
      end
      @(posedge clk); #1;
    end
    trap_ack = 1'b0;
    total++;
    if ({state, retire_count} !== {SF, 32'(exp_ret)}) begin
      bad++;
      $display("FAIL dmem_to_exit st=%0d ret=%0d want st=0 ret=%0d", state, retire_count, exp_ret);
    end
  endtask
  task automatic test_muldiv();
    cyc_t e;
`ifdef CU_MEXT_EN
    cyc_t t[$] = '{'{RTYP, IR, SF, IREQ | IRW, C0}, '{RTYP, NO, SD, Z, C0}, '{RTYP, NO, SE, Z, C0},
                   '{RTYP, MD, SX, MDS, C0}, '{RTYP, NO, SX, Z, C0}, '{RTYP, NO, SX, Z, C0},
                   '{RTYP, NO, SX, Z, C0}, '{RTYP, NO, SX, Z, C0}, '{RTYP, MD, SX, Z, C0},
                   '{RTYP, NO, SW, RW | PCW, C0}};
    exp_ret++;
`else
    cyc_t t[$] = '{'{RTYP, IR, SF, IREQ | IRW, C0}, '{RTYP, NO, SD, Z, C0}, '{RTYP, NO, ST, TRP, C1},
                   '{RTYP, AK, ST, TRP | PCW, C1}};
`endif
    funct7 = 7'b0000001;
    foreach (t[i]) begin
      opcode = t[i].op;
      {imem_ready, dmem_ready, md_done, trap_ack} = t[i].in;
      sb.push_back(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({state, obs(), trap_cause} !== {e.st, e.b, e.c}) begin
        bad++;
        $display("FAIL muldiv[%0d] st=%0d out=%b cause=%0d want st=%0d out=%b cause=%0d", i, state, obs(), trap_cause, e.st, e.b, e.c);
      end
      @(posedge clk); #1;
    end
    {funct7, md_done, trap_ack} = '0;
    total++;
    if ({state, retire_count} !== {SF, 32'(exp_ret)}) begin
      bad++;
      $display("FAIL muldiv_exit st=%0d ret=%0d want st=0 ret=%0d", state, retire_count, exp_ret);
    end
  endtask
  task automatic test_reset_mid();
    cyc_t e;
    cyc_t t[$] = '{'{LW, IR, SF, IREQ | IRW, C0}, '{LW, NO, SD, Z, C0}, '{LW, NO, SE, Z, C0},
                   '{LW, NO, SM, DREQ | MRD, C0}};
    foreach (t[i]) begin
      opcode = t[i].op;
      {imem_ready, dmem_ready, md_done, trap_ack} = t[i].in;
      sb.push_back(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({state, obs(), trap_cause} !== {e.st, e.b, e.c}) begin
        bad++;
        $display("FAIL rst_mid[%0d] st=%0d out=%b cause=%0d want st=%0d out=%b cause=%0d", i, state, obs(), trap_cause, e.st, e.b, e.c);
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    exp_ret = 0;
    total++;
    if ({state, retire_count, mem_to_reg, dmem_req} !== {SF, 32'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL rst_mid_state st=%0d ret=%0d m2r=%b dreq=%b want st=0 ret=0 m2r=0 dreq=0", state, retire_count, mem_to_reg, dmem_req);
    end
    @(negedge clk);
    total++;
    if (imem_req !== 1'b0) begin
      bad++;
      $display("FAIL rst_gate imem_req=%b want 0", imem_req);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask
  initial begin
    test_reset();
    test_addi();
    test_load();
    test_store();
    test_branch();
    test_back_to_back();
    test_illegal();
    test_imem_timeout();
    test_dmem_timeout();
    test_muldiv();
    test_reset_mid();
    test_addi();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
